hazard_stall_ctrl: RTL and testbench

- Pipeline stall/bubble controller for the 5-stage MIPS core.
- Decides each cycle whether the F, D and ID/EX pipeline registers are held (pause) and whether a bubble is inserted into E.
- Owns the multiply/divide busy sequencer that stalls HI/LO-using instructions.
- Sits beside the pipeline registers:
  - Drives the PC hold and the IF/ID `pause` input.
  - Drives the synchronous clear used to bubble ID/EX.

---
 rtl/hazard_stall_ctrl_if.sv | 41 ++++
 rtl/hazard_stall_ctrl.sv | 81 ++++++++
 tb/tb_hazard_stall_ctrl.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_stall_ctrl_if.sv
// Pipeline-to-hazard-controller bundle: D/E/M operand info in, stall controls out.
// STALL_STAT_EN adds the stall statistic counters to the bundle.
interface hazard_stall_ctrl_if;
  logic [4:0] D_rs_addr;
  logic [4:0] D_rt_addr;
  logic [1:0] D_tuse_rs;
  logic [1:0] D_tuse_rt;
  logic       D_md;
  logic [4:0] E_wa;
  logic [1:0] E_tnew;
  logic [4:0] M_wa;
  logic [1:0] M_tnew;
  logic       E_start;
  logic       E_is_div;
  logic       F_pause;
  logic       D_pause;
  logic       E_flush;
  logic       md_busy;
`ifdef STALL_STAT_EN
  logic [31:0] stall_data_cnt;
  logic [31:0] stall_md_cnt;
`endif

  modport master (
    output D_rs_addr, D_rt_addr, D_tuse_rs, D_tuse_rt, D_md,
    output E_wa, E_tnew, M_wa, M_tnew, E_start, E_is_div,
`ifdef STALL_STAT_EN
    input  stall_data_cnt, stall_md_cnt,
`endif
    input  F_pause, D_pause, E_flush, md_busy
  );

  modport slave (
    input  D_rs_addr, D_rt_addr, D_tuse_rs, D_tuse_rt, D_md,
    input  E_wa, E_tnew, M_wa, M_tnew, E_start, E_is_div,
`ifdef STALL_STAT_EN
    output stall_data_cnt, stall_md_cnt,
`endif
    output F_pause, D_pause, E_flush, md_busy
  );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// Stall/bubble controller for the 5-stage MIPS core with multiply/divide busy sequencer.
// Optional macro STALL_STAT_EN adds saturating data/md stall cycle counters.
module hazard_stall_ctrl #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10,
  parameter int unsigned CNT_W       = 4
) (
  input logic           clk,
  input logic           reset,
  hazard_stall_ctrl_if.slave bus
);

  logic             rsStall;
  logic             rtStall;
  logic             dataStall;
  logic             mdBusy;
  logic             mdStall;
  logic             stall;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // A producer stalls the reader only when its result arrives later than the reader needs it.
  assign rsStall = (bus.D_rs_addr != 5'd0) &&
                   (((bus.D_rs_addr == bus.E_wa) && (bus.E_tnew > bus.D_tuse_rs)) ||
                    ((bus.D_rs_addr == bus.M_wa) && (bus.M_tnew > bus.D_tuse_rs)));
  assign rtStall = (bus.D_rt_addr != 5'd0) &&
                   (((bus.D_rt_addr == bus.E_wa) && (bus.E_tnew > bus.D_tuse_rt)) ||
                    ((bus.D_rt_addr == bus.M_wa) && (bus.M_tnew > bus.D_tuse_rt)));
  assign dataStall = rsStall | rtStall;

  assign mdBusy  = (cnt_q != '0);
  assign mdStall = bus.D_md && (bus.E_start || mdBusy);
  assign stall   = dataStall | mdStall;

  assign bus.F_pause = stall;
  assign bus.D_pause = stall;
  assign bus.E_flush = stall;
  assign bus.md_busy = mdBusy;

  // A start that arrives while the unit is busy is dropped rather than restarting the count.
  always_comb begin
    cnt_d = cnt_q;
    if (!mdBusy && bus.E_start) begin
      cnt_d = bus.E_is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
    end else if (mdBusy) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

`ifdef STALL_STAT_EN
  logic [31:0] dataCnt_q;
  logic [31:0] mdCnt_q;

  // Cycles with both stall causes are charged to the data counter only.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dataCnt_q <= '0;
      mdCnt_q   <= '0;
    end else begin
      if (dataStall && (dataCnt_q != 32'hFFFF_FFFF)) begin
        dataCnt_q <= dataCnt_q + 32'd1;
      end
      if (mdStall && !dataStall && (mdCnt_q != 32'hFFFF_FFFF)) begin
        mdCnt_q <= mdCnt_q + 32'd1;
      end
    end
  end

  assign bus.stall_data_cnt = dataCnt_q;
  assign bus.stall_md_cnt   = mdCnt_q;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Self-checking bench for hazard_stall_ctrl: directed scenarios plus randomized traffic
// against a cycle-window reference model.
module tb_hazard_stall_ctrl;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  int   cyc;
  int   busyEnd;
  bit   inReset;
  longint unsigned dataCnt;
  longint unsigned mdCnt;
  int   busyCount;

  hazard_stall_ctrl_if bus ();

  hazard_stall_ctrl dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic [4:0] rs, input logic [4:0] rt,
                               input logic [1:0] tuseRs, input logic [1:0] tuseRt,
                               input logic dmd, input logic [4:0] ewa, input logic [1:0] etnew,
                               input logic [4:0] mwa, input logic [1:0] mtnew,
                               input logic start, input logic isDiv);
    bus.D_rs_addr = rs;
    bus.D_rt_addr = rt;
    bus.D_tuse_rs = tuseRs;
    bus.D_tuse_rt = tuseRt;
    bus.D_md      = dmd;
    bus.E_wa      = ewa;
    bus.E_tnew    = etnew;
    bus.M_wa      = mwa;
    bus.M_tnew    = mtnew;
    bus.E_start   = start;
    bus.E_is_div  = isDiv;
  endtask

  // Reference data hazard: any used, non-$0 source whose producer is still too far away.
  function automatic bit modelDataStall();
    bit hit = 0;
    for (int op = 0; op < 2; op++) begin
      int addr = (op == 0) ? int'(bus.D_rs_addr) : int'(bus.D_rt_addr);
      int tuse = (op == 0) ? int'(bus.D_tuse_rs) : int'(bus.D_tuse_rt);
      if (addr != 0) begin
        if (addr == int'(bus.E_wa) && int'(bus.E_tnew) > tuse) hit = 1;
        if (addr == int'(bus.M_wa) && int'(bus.M_tnew) > tuse) hit = 1;
      end
    end
    return hit;
  endfunction

  // Unit is busy in every cycle index from the one after the start edge up to busyEnd.
  function automatic bit modelBusy();
    return !inReset && (cyc <= busyEnd);
  endfunction

  task automatic stepCycle();
    bit mB, dS, mS, st;
    #2;
    mB = modelBusy();
    dS = modelDataStall();
    mS = bus.D_md && (bus.E_start || mB);
    st = dS | mS;
    checkOutput("F_pause", {31'd0, bus.F_pause}, {31'd0, st});
    checkOutput("D_pause", {31'd0, bus.D_pause}, {31'd0, st});
    checkOutput("E_flush", {31'd0, bus.E_flush}, {31'd0, st});
    checkOutput("md_busy", {31'd0, bus.md_busy}, {31'd0, mB});
`ifdef STALL_STAT_EN
    checkOutput("stall_data_cnt", bus.stall_data_cnt, 32'(dataCnt));
    checkOutput("stall_md_cnt", bus.stall_md_cnt, 32'(mdCnt));
`endif
    @(posedge clk);
    if (!inReset) begin
      if (!mB && bus.E_start) busyEnd = cyc + (bus.E_is_div ? 10 : 5);
      if (dS) begin
        if (dataCnt < 64'hFFFF_FFFF) dataCnt++;
      end else if (mS) begin
        if (mdCnt < 64'hFFFF_FFFF) mdCnt++;
      end
    end
    cyc++;
    #1;
  endtask

  task automatic doReset();
    reset = 1'b0;
    #1;
    inReset = 1;
    busyEnd = -1;
    dataCnt = 0;
    mdCnt   = 0;
    checkOutput("rst_md_busy", {31'd0, bus.md_busy}, 32'd0);
    stepCycle();
    stepCycle();
    reset   = 1'b1;
    inReset = 0;
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    cyc     = 0;
    busyEnd = -1;
    dataCnt = 0;
    mdCnt   = 0;
    inReset = 1;
    reset   = 1'b0;
    applyStimulus(0, 0, 3, 3, 0, 0, 0, 0, 0, 0, 0);
    #3;
    checkOutput("init_md_busy", {31'd0, bus.md_busy}, 32'd0);
    checkOutput("init_stall", {31'd0, bus.F_pause}, 32'd0);
    @(posedge clk);
    #1;
    reset   = 1'b1;
    inReset = 0;

    // lw-use stall, then resolved once the load reaches M with tnew=1
    applyStimulus(8, 0, 1, 3, 0, 8, 2, 0, 0, 0, 0);
    #1;
    checkOutput("lwuse_stall", {31'd0, bus.F_pause}, 32'd1);
    stepCycle();
    applyStimulus(8, 0, 1, 3, 0, 0, 0, 8, 1, 0, 0);
    #1;
    checkOutput("lwuse_clear", {31'd0, bus.F_pause}, 32'd0);
    stepCycle();

    // $0 source and unused operand never stall
    applyStimulus(0, 0, 0, 3, 0, 0, 2, 0, 0, 0, 0);
    #1;
    checkOutput("zero_reg", {31'd0, bus.D_pause}, 32'd0);
    stepCycle();
    applyStimulus(0, 9, 3, 3, 0, 9, 2, 0, 0, 0, 0);
    #1;
    checkOutput("tuse3", {31'd0, bus.E_flush}, 32'd0);
    stepCycle();

    // mult sequence with an md instruction waiting in D
    applyStimulus(0, 0, 3, 3, 1, 0, 0, 0, 0, 1, 0);
    #1;
    checkOutput("mult_start_stall", {31'd0, bus.F_pause}, 32'd1);
    stepCycle();
    bus.E_start = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      checkOutput($sformatf("mult_busy_%0d", i), {31'd0, bus.md_busy}, (i <= 5) ? 32'd1 : 32'd0);
      checkOutput($sformatf("mult_stall_%0d", i), {31'd0, bus.D_pause}, (i <= 5) ? 32'd1 : 32'd0);
      stepCycle();
    end

    // div ignores a mult start issued during busy cycle 3
    applyStimulus(0, 0, 3, 3, 0, 0, 0, 0, 0, 1, 1);
    stepCycle();
    busyCount = 0;
    for (int i = 0; i < 20; i++) begin
      bus.E_start  = (i == 2);
      bus.E_is_div = 1'b0;
      if (bus.md_busy) busyCount++;
      stepCycle();
    end
    checkOutput("div_busy_len", 32'(busyCount), 32'd10);

    // asynchronous reset in busy cycle 4 of a divide, then a fresh mult
    applyStimulus(0, 0, 3, 3, 0, 0, 0, 0, 0, 1, 1);
    stepCycle();
    bus.E_start = 1'b0;
    for (int i = 0; i < 3; i++) stepCycle();
    reset = 1'b0;
    #1;
    checkOutput("async_abort", {31'd0, bus.md_busy}, 32'd0);
    inReset = 1;
    busyEnd = -1;
    dataCnt = 0;
    mdCnt   = 0;
    stepCycle();
    reset   = 1'b1;
    inReset = 0;
    applyStimulus(0, 0, 3, 3, 0, 0, 0, 0, 0, 1, 0);
    stepCycle();
    bus.E_start = 1'b0;
    busyCount = 0;
    for (int i = 0; i < 8; i++) begin
      if (bus.md_busy) busyCount++;
      stepCycle();
    end
    checkOutput("post_rst_mult_len", 32'(busyCount), 32'd5);

`ifdef STALL_STAT_EN
    doReset();
    applyStimulus(8, 0, 1, 3, 0, 8, 2, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) stepCycle();
    applyStimulus(0, 0, 3, 3, 1, 0, 0, 0, 0, 1, 0);
    stepCycle();
    bus.E_start = 1'b0;
    for (int i = 0; i < 4; i++) stepCycle();
    bus.D_md = 1'b0;
    stepCycle();
    checkOutput("stat_data", bus.stall_data_cnt, 32'd3);
    checkOutput("stat_md", bus.stall_md_cnt, 32'd5);
`endif

    // randomized traffic with periodic resets
    for (int n = 0; n < 600; n++) begin
      if (n % 150 == 149) doReset();
      applyStimulus(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                    2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                    ($urandom_range(0, 2) == 0),
                    5'($urandom_range(0, 3)), 2'($urandom_range(0, 2)),
                    5'($urandom_range(0, 3)), 2'($urandom_range(0, 2)),
                    ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)));
      stepCycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
